// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared constants, FSM states and ASCII-to-code mapping for the enigma text feeder
package enigma_pkg;

  localparam int ROTOR_ENTRIES = 192;
  localparam int CODE_W        = 6;
  localparam int FIFO_DEPTH    = 4;
  localparam int IDX_W         = 8;

  localparam logic [CODE_W-1:0] SPACE_CODE = 6'h1a;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic              ok;
    logic [CODE_W-1:0] code;
  } map_t;

  // Inverse of the core's 64-symbol table; letters use the low six ASCII bits
  // with a fixed offset so the ranges need no subtraction on the full byte.
  function automatic map_t ascii_to_code(input logic [7:0] c);
    map_t m;
    m.ok   = 1'b1;
    m.code = SPACE_CODE;
    if (c >= 8'h61 && c <= 8'h7a) begin
      m.code = c[5:0] - 6'h21;
    end else if (c >= 8'h41 && c <= 8'h5a) begin
      m.code = c[5:0] + 6'h1f;
    end else begin
      case (c)
        8'h20:   m.code = 6'h1a;
        8'h21:   m.code = 6'h1b;
        8'h2c:   m.code = 6'h1c;
        8'h2d:   m.code = 6'h1d;
        8'h2e:   m.code = 6'h1e;
        8'h0a:   m.code = 6'h1f;
        8'h3a:   m.code = 6'h3a;
        8'h23:   m.code = 6'h3b;
        8'h3b:   m.code = 6'h3c;
        8'h5f:   m.code = 6'h3d;
        8'h2b:   m.code = 6'h3e;
        8'h26:   m.code = 6'h3f;
        default: m.ok   = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/enigma_sym_fifo.sv
// rtl/enigma_sym_fifo.sv - small symbol FIFO between text mapping and the core encrypt port
module enigma_sym_fifo
  import enigma_pkg::*;
(
  input  logic              clk,
  input  logic              srstn,
  input  logic              push,
  input  logic [CODE_W-1:0] push_data,
  input  logic              pop,
  output logic [CODE_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // A pop frees the slot this cycle, so a full FIFO may still take a push.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/enigma_text_feeder.sv
// rtl/enigma_text_feeder.sv - loads rotor tables into the enigma core, then streams mapped text symbols
module enigma_text_feeder
  import enigma_pkg::*;
(
  input  logic       clk,
  input  logic       srstn,
  input  logic       start,
  input  logic       mode_in,
  input  logic       rot_valid,
  input  logic [5:0] rot_data,
  output logic       rot_ready,
  input  logic       txt_valid,
  input  logic [7:0] txt_ascii,
  input  logic       txt_last,
  output logic       txt_ready,
  output logic       load,
  output logic [7:0] load_idx,
  output logic [5:0] code_in,
  output logic       encrypt,
  output logic       crypt_mode,
  output logic       err_char,
  output logic       busy,
  output logic       done
);

  state_t            state;
  logic [IDX_W-1:0]  entry_cnt;
  map_t              mapped;
  logic [CODE_W-1:0] push_code;
  logic [CODE_W-1:0] head_code;
  logic              txt_acc;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  // Leaving STREAM on txt_last is what blocks further bytes until the next session.
  assign rot_ready = (state == ST_LOAD);
  assign txt_ready = (state == ST_STREAM) & ~fifo_full;
  assign busy      = (state != ST_IDLE);
  assign txt_acc   = txt_valid & txt_ready;
  assign fifo_pop  = ((state == ST_STREAM) | (state == ST_FLUSH)) & ~fifo_empty;

  assign mapped    = ascii_to_code(txt_ascii);
  assign push_code = mapped.ok ? mapped.code : SPACE_CODE;

  enigma_sym_fifo u_fifo (
    .clk       (clk),
    .srstn     (srstn),
    .push      (txt_acc),
    .push_data (push_code),
    .pop       (fifo_pop),
    .pop_data  (head_code),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state      <= ST_IDLE;
      entry_cnt  <= '0;
      load       <= 1'b0;
      load_idx   <= '0;
      code_in    <= '0;
      encrypt    <= 1'b0;
      crypt_mode <= 1'b0;
      err_char   <= 1'b0;
      done       <= 1'b0;
    end else begin
      err_char <= txt_acc & ~mapped.ok;
      done     <= 1'b0;
      encrypt  <= fifo_pop;
      if (fifo_pop) code_in <= head_code;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            crypt_mode <= mode_in;
            entry_cnt  <= '0;
          end
        end
        // load stays high across rot_valid gaps; rewriting the same entry is harmless.
        ST_LOAD: begin
          if (rot_valid) begin
            load      <= 1'b1;
            load_idx  <= entry_cnt;
            code_in   <= rot_data;
            entry_cnt <= entry_cnt + IDX_W'(1);
            if (entry_cnt == IDX_W'(ROTOR_ENTRIES - 1)) state <= ST_GAP;
          end
        end
        ST_GAP: begin
          load  <= 1'b0;
          state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (txt_acc && txt_last) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
